// File: rtl/piece_drop_engine_if.sv
// Handshake/bus bundle between the game controller and the piece drop engine.
// master = game-state side (drives requests and the settled board),
// slave  = drop engine (drives the falling-piece view and status pulses).
interface piece_drop_engine_if #(
  parameter int ROWS = 20,
  parameter int COLS = 10
);
  localparam int RW = $clog2(ROWS);

  logic                 start;
  logic [2:0]           piece_type;
  logic                 drop_tick;
  logic                 hard_drop;
  logic [ROWS*COLS-1:0] board_in;
  logic [ROWS*COLS-1:0] active_array;
  logic [RW-1:0]        piece_row;
  logic                 busy;
  logic                 landed;
  logic                 spawn_blocked;

  modport master (
    output start, piece_type, drop_tick, hard_drop, board_in,
    input  active_array, piece_row, busy, landed, spawn_blocked
  );

  modport slave (
    input  start, piece_type, drop_tick, hard_drop, board_in,
    output active_array, piece_row, busy, landed, spawn_blocked
  );
endinterface

// File: rtl/piece_drop_engine.sv
// Gravity engine for a single falling tetromino. The piece is spawned at
// row 0 / SPAWN_COL and moves down one row per gravity tick (or per cycle
// while hard_drop is held) until the floor or a settled cell stops it.
// Each piece is described as four row masks (one per dr = 0..3) so that
// collision and display both reduce to row-wise AND/OR operations.
module piece_drop_engine #(
  parameter int ROWS      = 20,
  parameter int COLS      = 10,
  parameter int SPAWN_COL = 4,
  parameter int RW        = $clog2(ROWS)
) (
  input logic                clk,
  input logic                rst,
  piece_drop_engine_if.slave bus
);

  typedef enum logic [2:0] {IDLE, SPAWN, FALL, LAND, BLOCK} state_t;

  // Column masks around the anchor column (dc = -1, 0, +1, +2).
  localparam logic [COLS-1:0] C0  = COLS'(1) << SPAWN_COL;
  localparam logic [COLS-1:0] CM1 = C0 >> 1;
  localparam logic [COLS-1:0] CP1 = C0 << 1;
  localparam logic [COLS-1:0] CP2 = C0 << 2;
  localparam logic [RW+1:0]   ROWS_L = (RW+2)'(ROWS);

  typedef logic [3:0][COLS-1:0] shape_t;

  state_t         state_reg, state_next;
  logic [RW-1:0]  row_reg, row_next;
  logic [2:0]     type_reg, type_next;

  shape_t               shape_cur;
  logic [COLS-1:0]      board_rows [ROWS];
  logic [ROWS*COLS-1:0] active_flat;
  logic [RW+1:0]        probe_row;
  logic [RW+1:0]        probe_sum;
  logic                 fits_ok;
  logic                 show;

  // Row masks of each piece, index = dr. Type 7 never gets latched.
  function automatic shape_t shape_of(input logic [2:0] t);
    shape_t s;
    s = '0;
    case (t)
      3'd0: begin s[0] = C0;        s[1] = C0;        s[2] = C0;       s[3] = C0; end
      3'd1: begin s[0] = C0 | CP1;  s[1] = C0 | CP1;                                end
      3'd2: begin s[0] = C0;        s[1] = C0;        s[2] = C0 | CP1;             end
      3'd3: begin s[0] = CP1;       s[1] = CP1;       s[2] = CP1 | C0;             end
      3'd4: begin s[0] = CP1 | CP2; s[1] = C0 | CP1;                                end
      3'd5: begin s[0] = C0 | CP1;  s[1] = CP1 | CP2;                               end
      3'd6: begin s[0] = C0;        s[1] = CM1 | C0 | CP1;                          end
      default: s = '0;
    endcase
    return s;
  endfunction

  assign shape_cur = shape_of(type_reg);
  assign show      = (state_reg == FALL) || (state_reg == LAND);

  // Row-wise view of the settled board and the displayed piece overlay.
  for (genvar gi = 0; gi < ROWS; gi++) begin : g_rows
    logic [RW+1:0] off;
    assign board_rows[gi] = bus.board_in[gi*COLS +: COLS];
    // off wraps to a large value for rows above the anchor, so one compare suffices.
    assign off = (RW+2)'(gi) - {2'b00, row_reg};
    assign active_flat[gi*COLS +: COLS] =
      (show && (off < (RW+2)'(4))) ? shape_cur[off[1:0]] : '0;
  end

  // Collision probe: row 0 when spawning, otherwise one row below the anchor.
  always_comb begin
    probe_row = (state_reg == SPAWN) ? '0 : ({2'b00, row_reg} + (RW+2)'(1));
    probe_sum = '0;
    fits_ok   = 1'b1;
    for (int d = 0; d < 4; d++) begin
      probe_sum = probe_row + (RW+2)'(d);
      if (shape_cur[d] != '0) begin
        if (probe_sum >= ROWS_L) begin
          fits_ok = 1'b0;
        end else if ((board_rows[probe_sum[RW-1:0]] & shape_cur[d]) != '0) begin
          fits_ok = 1'b0;
        end
      end
    end
  end

  // Next-state logic: spawn, fall, land or block.
  always_comb begin
    state_next = state_reg;
    row_next   = row_reg;
    type_next  = type_reg;
    case (state_reg)
      IDLE: begin
        if (bus.start && (bus.piece_type != 3'd7)) begin
          type_next  = bus.piece_type;
          row_next   = '0;
          state_next = SPAWN;
        end
      end
      SPAWN: state_next = fits_ok ? FALL : BLOCK;
      FALL: begin
        if (bus.drop_tick || bus.hard_drop) begin
          if (fits_ok) row_next = probe_row[RW-1:0];
          else         state_next = LAND;
        end
      end
      LAND:    state_next = IDLE;
      BLOCK:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State, anchor row and latched piece type registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg <= IDLE;
      row_reg   <= '0;
      type_reg  <= '0;
    end else begin
      state_reg <= state_next;
      row_reg   <= row_next;
      type_reg  <= type_next;
    end
  end

  assign bus.active_array  = active_flat;
  assign bus.piece_row     = row_reg;
  assign bus.busy          = (state_reg != IDLE);
  assign bus.landed        = (state_reg == LAND);
  assign bus.spawn_blocked = (state_reg == BLOCK);

endmodule

// File: tb/tb_piece_drop_engine.sv
// Directed bench for piece_drop_engine: a vector table for short sequences
// plus hand-written drops down to the floor or onto a settled cell.
module tb_piece_drop_engine;
  localparam int ROWS = 20;
  localparam int COLS = 10;
  localparam int SPC  = 4;
  localparam int RW   = $clog2(ROWS);
  localparam int N    = ROWS * COLS;

  logic clk;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  piece_drop_engine_if #(.ROWS(ROWS), .COLS(COLS)) bus ();

  piece_drop_engine #(.ROWS(ROWS), .COLS(COLS), .SPAWN_COL(SPC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst_n;
    logic       start;
    logic [2:0] ptype;
    logic       tick;
    logic       hard;
    int         bsel;
    logic       e_busy;
    logic       e_landed;
    logic       e_blk;
    int         e_row;
    int         e_type;
    logic       e_show;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t v(logic rn, logic st, logic [2:0] pt, logic tk, logic hd,
                             int bs, logic eb, logic el, logic ebl, int er, int et,
                             logic es);
    vec_t r;
    r.rst_n = rn; r.start = st; r.ptype = pt; r.tick = tk; r.hard = hd; r.bsel = bs;
    r.e_busy = eb; r.e_landed = el; r.e_blk = ebl; r.e_row = er; r.e_type = et;
    r.e_show = es;
    return r;
  endfunction

  // 0: empty, 1: cell (10,4) occupied, 2: cell (1,4) occupied
  function automatic logic [N-1:0] board_of(int sel);
    logic [N-1:0] b;
    b = '0;
    if (sel == 1) b[10*COLS + 4] = 1'b1;
    if (sel == 2) b[1*COLS + 4]  = 1'b1;
    return b;
  endfunction

  // Expected overlay built from the (dr, dc) offset list of each piece.
  function automatic logic [N-1:0] exp_active(int t, int row, logic show);
    logic [N-1:0] a;
    int dr[4];
    int dc[4];
    int r;
    int c;
    a = '0;
    case (t)
      0: begin dr = '{0, 1, 2, 3}; dc = '{0, 0, 0, 0};  end
      1: begin dr = '{0, 0, 1, 1}; dc = '{0, 1, 0, 1};  end
      2: begin dr = '{0, 1, 2, 2}; dc = '{0, 0, 0, 1};  end
      3: begin dr = '{0, 1, 2, 2}; dc = '{1, 1, 1, 0};  end
      4: begin dr = '{0, 0, 1, 1}; dc = '{1, 2, 0, 1};  end
      5: begin dr = '{0, 0, 1, 1}; dc = '{0, 1, 1, 2};  end
      default: begin dr = '{0, 1, 1, 1}; dc = '{0, -1, 0, 1}; end
    endcase
    if (show) begin
      for (int i = 0; i < 4; i++) begin
        r = row + dr[i];
        c = SPC + dc[i];
        if (r < ROWS) a[r*COLS + c] = 1'b1;
      end
    end
    return a;
  endfunction

  task automatic step(logic rn, logic st, logic [2:0] pt, logic tk, logic hd, int bs);
    rst            = rn;
    bus.start      = st;
    bus.piece_type = pt;
    bus.drop_tick  = tk;
    bus.hard_drop  = hd;
    bus.board_in   = board_of(bs);
    @(posedge clk);
    #1;
  endtask

  task automatic check(string name, logic eb, logic el, logic ebl, int er, int et,
                       logic es);
    logic [N-1:0]  ea;
    logic [RW-1:0] erow;
    ea   = exp_active(et, er, es);
    erow = RW'(er);
    checks++;
    if (bus.busy !== eb || bus.landed !== el || bus.spawn_blocked !== ebl ||
        bus.piece_row !== erow || bus.active_array !== ea) begin
      errors++;
      $display("FAIL %s: got busy=%b landed=%b blk=%b row=%0d act=%h; expected busy=%b landed=%b blk=%b row=%0d act=%h",
               name, bus.busy, bus.landed, bus.spawn_blocked, bus.piece_row,
               bus.active_array, eb, el, ebl, erow, ea);
    end else begin
      $display("ok   %s: busy=%b landed=%b blk=%b row=%0d", name, bus.busy,
               bus.landed, bus.spawn_blocked, bus.piece_row);
    end
  endtask

  // Spawn a piece, step it down to final_row, then check the landing pulse.
  task automatic run_drop(string name, logic [2:0] pt, int bs, logic use_hard, int final_row);
    step(1, 1, pt, 0, 0, bs);
    check($sformatf("%s spawn", name), 1, 0, 0, 0, pt, 0);
    step(1, 0, 0, 0, 0, bs);
    check($sformatf("%s visible", name), 1, 0, 0, 0, pt, 1);
    for (int k = 1; k <= final_row; k++) begin
      step(1, 0, 0, !use_hard, use_hard, bs);
      check($sformatf("%s step%0d", name, k), 1, 0, 0, k, pt, 1);
    end
    step(1, 0, 0, !use_hard, use_hard, bs);
    check($sformatf("%s land", name), 1, 1, 0, final_row, pt, 1);
    step(1, 0, 0, !use_hard, use_hard, bs);
    check($sformatf("%s idle", name), 0, 0, 0, final_row, pt, 0);
    step(1, 0, 0, 0, 0, bs);
  endtask

  initial begin
    rst            = 1'b0;
    bus.start      = 1'b0;
    bus.piece_type = 3'd0;
    bus.drop_tick  = 1'b0;
    bus.hard_drop  = 1'b0;
    bus.board_in   = '0;

    //         rn st pt tk hd bs  busy lnd blk row type show
    tbl.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));  // reset
    tbl.push_back(v(1, 1, 7, 0, 0, 0, 0, 0, 0, 0, 0, 0));  // type 7 ignored
    tbl.push_back(v(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(v(1, 1, 2, 0, 0, 2, 1, 0, 0, 0, 0, 0));  // L over (1,4): SPAWN
    tbl.push_back(v(1, 0, 0, 0, 0, 2, 1, 0, 1, 0, 0, 0));  // BLOCK pulse
    tbl.push_back(v(1, 0, 0, 0, 0, 2, 0, 0, 0, 0, 0, 0));  // back to IDLE
    tbl.push_back(v(1, 1, 5, 0, 0, 0, 1, 0, 0, 0, 0, 0));  // Z spawn
    tbl.push_back(v(1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 5, 1));  // visible at row 0
    tbl.push_back(v(1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 5, 1));  // no step: hold
    for (int k = 1; k <= 5; k++)
      tbl.push_back(v(1, 0, 0, 1, 0, 0, 1, 0, 0, k, 5, 1));
    tbl.push_back(v(1, 0, 0, 1, 1, 0, 1, 0, 0, 6, 5, 1));  // tick+hard = one step
    tbl.push_back(v(1, 1, 3, 0, 0, 0, 1, 0, 0, 6, 5, 1));  // start while busy
    tbl.push_back(v(1, 0, 0, 1, 0, 0, 1, 0, 0, 7, 5, 1));  // still Z
    tbl.push_back(v(1, 0, 0, 1, 0, 0, 1, 0, 0, 8, 5, 1));
    tbl.push_back(v(1, 0, 0, 1, 0, 0, 1, 0, 0, 9, 5, 1));
    tbl.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));  // reset mid-fall
    tbl.push_back(v(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(v(1, 1, 7, 0, 0, 0, 0, 0, 0, 0, 0, 0));  // type 7 ignored again

    foreach (tbl[i]) begin
      step(tbl[i].rst_n, tbl[i].start, tbl[i].ptype, tbl[i].tick, tbl[i].hard, tbl[i].bsel);
      check($sformatf("vec%0d", i), tbl[i].e_busy, tbl[i].e_landed, tbl[i].e_blk,
            tbl[i].e_row, tbl[i].e_type, tbl[i].e_show);
    end

    run_drop("I_ticks", 3'd0, 0, 1'b0, 16);
    run_drop("T_hard",  3'd6, 0, 1'b1, 18);
    run_drop("O_obst",  3'd1, 1, 1'b0, 8);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/piece_drop_engine.md
Name: piece_drop_engine

Overview:
- Parametrised gravity engine for one falling tetromino on a ROWS x COLS playfield.
- Spawns the selected piece at a fixed column and advances it one row per gravity tick or per cycle during hard drop.
- Collision checks use both the floor and the settled-cell board, not a fixed per-type row limit.
- Sits between the game-state FSM (supplies piece type, ticks, settled board) and the board-merge/line-clear logic (consumes active_array and landed).

Parameters:
- ROWS, 20, playfield height in rows; row 0 is the top.
- COLS, 10, playfield width in columns.
- SPAWN_COL, 4, anchor column of a newly spawned piece; legal range 1..COLS-3.
- RW, $clog2(ROWS), width of the row counter (derived; do not override).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-low reset.
- start  in  1  spawn request; sampled only in IDLE.
- piece_type  in  3  0=I, 1=O, 2=L, 3=J, 4=S, 5=Z, 6=T; 7 is invalid.
- drop_tick  in  1  gravity strobe, one-cycle pulse.
- hard_drop  in  1  level; while high in FALL, the piece descends one row per cycle.
- board_in  in  ROWS*COLS  settled cells, indexed [row][col]; 1 = occupied.
- active_array  out  ROWS*COLS  cells of the falling piece only.
- piece_row  out  RW  current anchor row.
- busy  out  1  high whenever state is not IDLE.
- landed  out  1  one-cycle pulse; piece has come to rest.
- spawn_blocked  out  1  one-cycle pulse; the spawn position overlaps board_in (game over).

Behaviour:
- Cell offsets are (dr, dc) relative to (piece_row, SPAWN_COL):
  - I: (0,0)(1,0)(2,0)(3,0)
  - O: (0,0)(0,1)(1,0)(1,1)
  - L: (0,0)(1,0)(2,0)(2,1)
  - J: (0,1)(1,1)(2,1)(2,0)
  - S: (0,1)(0,2)(1,0)(1,1)
  - Z: (0,0)(0,1)(1,1)(1,2)
  - T: (0,0)(1,-1)(1,0)(1,1)
- fits(r): combinational. True when every cell satisfies r+dr < ROWS and board_in at that cell is 0. Compute row sums at RW+2 bits so they cannot wrap.
- Registered state: FSM state, piece_row, latched type. Outputs are decoded from registered state.
- FSM states and transitions:
  - IDLE: on start=1 and piece_type != 7, latch the type, set piece_row=0, go to SPAWN. start with type 7 is ignored.
  - SPAWN (1 cycle): if fits(0), go to FALL; otherwise go to BLOCK.
  - FALL: a step is requested when drop_tick=1 or hard_drop=1.
    - Simultaneous drop_tick and hard_drop give one step, not two.
    - On a step: if fits(piece_row+1), increment piece_row; otherwise go to LAND with piece_row unchanged.
    - With no step request, hold.
  - LAND (1 cycle): landed=1, piece still shown at its final row; then go to IDLE.
  - BLOCK (1 cycle): spawn_blocked=1; then go to IDLE.
- active_array shows the piece cells only in FALL and LAND; it is all-zero in IDLE, SPAWN and BLOCK.
- board_in is re-evaluated every cycle. If a settled cell appears under the piece mid-fall, the next step lands it. The piece is never moved up.
- start is ignored while busy.
- Latency:
  - start at cycle t: SPAWN at t+1; piece visible in active_array at t+2.
  - A step request at cycle t updates piece_row at t+1.
  - A blocked step at cycle t gives landed=1 at t+1.
- Reset (rst=0 at a clock edge, any state, including mid-fall): state=IDLE, piece_row=0, type=0. All outputs 0 on the following cycle. The falling piece is discarded, with no landed pulse.

Test Plan:
- ROWS=20, COLS=10, SPAWN_COL=4, empty board, start with type 0 (I), 17 ticks -> piece_row reaches 16 after tick 16, with active_array rows 16..19 at col 4; tick 17 -> landed pulse one cycle later, then busy=0 and active_array=0.
- Empty board, type 6 (T), hard_drop held high -> piece_row increments every cycle until 18; landed pulses in the cycle after the first blocked step; cells (18,4)(19,3)(19,4)(19,5).
- board_in[10][4]=1, type 1 (O), repeated ticks -> rests at piece_row=8; the step from row 8 is rejected; landed=1.
- board_in[1][4]=1, start with type 2 (L) -> spawn_blocked pulse at t+2; active_array stays 0; busy back to 0 at t+3.
- piece_row=5 in FALL, drop_tick and hard_drop both high for one cycle -> piece_row=6 (not 7). start pulsed mid-fall with type 3 -> ignored; type latch unchanged.
- Drive rst=0 for one cycle mid-fall at piece_row=9 -> next cycle: busy=0, piece_row=0, active_array=0, landed=0. start with piece_type=7 in IDLE -> remains IDLE.
